// File: rtl/dino_pkg.sv
// Shared constants for the dino vertical-motion controller: game-state codes
// and the physics state encoding.
package dino_pkg;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_OVER = 2'b01;
    localparam logic [1:0] GS_PLAY = 2'b10;

    typedef enum logic [1:0] {
        JS_GROUND = 2'd0,
        JS_RISE   = 2'd1,
        JS_FALL   = 2'd2
    } js_t;

endpackage

// File: rtl/dino_phys_step.sv
// One airborne physics frame: integrates velocity into height, applies gravity,
// terminal velocity and the ceiling clamp, and flags landing. Purely combinational.
module dino_phys_step #(
    parameter int HEIGHT_W   = 8,
    parameter int VEL_W      = 6,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_HEIGHT = 120
) (
    input  logic [HEIGHT_W-1:0]       height,
    input  logic signed [VEL_W-1:0]   vel,
    input  logic                      fastDrop,
    output logic [HEIGHT_W-1:0]       nextHeight,
    output logic signed [VEL_W-1:0]   nextVel,
    output logic                      land,
    output logic                      clamp
);

    localparam int SW = HEIGHT_W + 2;
    localparam int DW = VEL_W + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_HEIGHT);

    logic signed [SW-1:0] sum;
    logic signed [DW-1:0] velDec;
    logic signed [DW-1:0] floorVel;

    // Terminal-velocity saturation; the widened operand absorbs the decrement overshoot.
    function automatic logic signed [VEL_W-1:0] sat_vel(
        input logic signed [DW-1:0] v,
        input logic signed [DW-1:0] floor_v
    );
        return (v < floor_v) ? VEL_W'(floor_v) : VEL_W'(v);
    endfunction

    always_comb begin
        sum        = SW'($signed({1'b0, height})) + SW'(vel);
        velDec     = DW'(vel) - (fastDrop ? DW'(3 * GRAVITY) : DW'(GRAVITY));
        floorVel   = fastDrop ? -DW'(2 * JUMP_VEL) : -DW'(JUMP_VEL);
        land       = (sum <= 0);
        clamp      = !land && (sum >= MAX_S);
        nextHeight = '0;
        nextVel    = '0;
        if (land) begin
            nextHeight = '0;
            nextVel    = '0;
        end else if (clamp) begin
            nextHeight = HEIGHT_W'(MAX_HEIGHT);
            nextVel    = '0;
        end else begin
            nextHeight = sum[HEIGHT_W-1:0];
            nextVel    = sat_vel(velDec, floorVel);
        end
    end

endmodule

// File: rtl/dino_jump_ctrl.sv
// T-rex vertical-motion controller: per-frame jump physics and ground/duck flags.
// Optional DINO_FAST_DROP_EN: holding duck while airborne triples gravity and doubles terminal velocity.
module dino_jump_ctrl
    import dino_pkg::*;
#(
    parameter int HEIGHT_W   = 8,
    parameter int VEL_W      = 6,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_HEIGHT = 120
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frameTick,
    input  logic [1:0]          gameState,
    input  logic                jumpBtn,
    input  logic                duckBtn,
    output logic                Airborne,
    output logic                onGround,
    output logic                isDuck,
    output logic [HEIGHT_W-1:0] dinoHeight,
    output logic                jumpPulse
);

    js_t                      state_q, state_d;
    logic [HEIGHT_W-1:0]      height_q, height_d;
    logic signed [VEL_W-1:0]  vel_q, vel_d;
    logic                     air_q, air_d;
    logic                     duck_q, duck_d;
    logic                     pulse_q, pulse_d;

    logic [HEIGHT_W-1:0]      stepHeight;
    logic signed [VEL_W-1:0]  stepVel;
    logic                     stepLand, stepClamp;
    logic                     fastDrop;

`ifdef DINO_FAST_DROP_EN
    assign fastDrop = duckBtn;
`else
    assign fastDrop = 1'b0;
`endif

    dino_phys_step #(
        .HEIGHT_W  (HEIGHT_W),
        .VEL_W     (VEL_W),
        .JUMP_VEL  (JUMP_VEL),
        .GRAVITY   (GRAVITY),
        .MAX_HEIGHT(MAX_HEIGHT)
    ) u_step (
        .height    (height_q),
        .vel       (vel_q),
        .fastDrop  (fastDrop),
        .nextHeight(stepHeight),
        .nextVel   (stepVel),
        .land      (stepLand),
        .clamp     (stepClamp)
    );

    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        vel_d    = vel_q;
        air_d    = air_q;
        duck_d   = duck_q;
        pulse_d  = 1'b0;
        if (frameTick) begin
            case (gameState)
                GS_OVER: begin
                    // Frozen in place, including mid-air.
                end
                GS_PLAY: begin
                    if (state_q == JS_GROUND) begin
                        if (jumpBtn && !duckBtn) begin
                            state_d  = JS_RISE;
                            height_d = HEIGHT_W'(JUMP_VEL);
                            vel_d    = VEL_W'(JUMP_VEL - GRAVITY);
                            air_d    = 1'b1;
                            duck_d   = 1'b0;
                            pulse_d  = 1'b1;
                        end else begin
                            duck_d = duckBtn;
                        end
                    end else begin
                        duck_d   = 1'b0;
                        height_d = stepHeight;
                        vel_d    = stepVel;
                        air_d    = !stepLand;
                        if (stepLand)
                            state_d = JS_GROUND;
                        else if (stepClamp || stepVel <= 0)
                            state_d = JS_FALL;
                        else
                            state_d = JS_RISE;
                    end
                end
                default: begin
                    state_d  = JS_GROUND;
                    height_d = '0;
                    vel_d    = '0;
                    air_d    = 1'b0;
                    duck_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= JS_GROUND;
            height_q <= '0;
            vel_q    <= '0;
            air_q    <= 1'b0;
            duck_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            height_q <= height_d;
            vel_q    <= vel_d;
            air_q    <= air_d;
            duck_q   <= duck_d;
            pulse_q  <= pulse_d;
        end
    end

    assign Airborne   = air_q;
    assign onGround   = ~air_q;
    assign isDuck     = duck_q;
    assign dinoHeight = height_q;
    assign jumpPulse  = pulse_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Self-checking bench for dino_jump_ctrl: directed jump scenarios plus random
// stimulus against an integer reference model (default and MAX_HEIGHT=40 instances).
module tb_dino_jump_ctrl;

    localparam int JV    = 12;
    localparam int G     = 1;
    localparam int MAXH0 = 120;
    localparam int MAXH1 = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frameTick = 1'b0;
    logic [1:0] gameState = 2'b00;
    logic       jumpBtn = 1'b0;
    logic       duckBtn = 1'b0;

    logic       air0, gnd0, duck0, pls0;
    logic [7:0] h0;
    logic       air1, gnd1, duck1, pls1;
    logic [7:0] h1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dino_jump_ctrl dut (
        .clk(clk), .rst(rst), .frameTick(frameTick), .gameState(gameState),
        .jumpBtn(jumpBtn), .duckBtn(duckBtn),
        .Airborne(air0), .onGround(gnd0), .isDuck(duck0),
        .dinoHeight(h0), .jumpPulse(pls0)
    );

    dino_jump_ctrl #(.MAX_HEIGHT(MAXH1)) dut_c (
        .clk(clk), .rst(rst), .frameTick(frameTick), .gameState(gameState),
        .jumpBtn(jumpBtn), .duckBtn(duckBtn),
        .Airborne(air1), .onGround(gnd1), .isDuck(duck1),
        .dinoHeight(h1), .jumpPulse(pls1)
    );

    typedef struct packed {
        int h;
        int v;
        bit air;
        bit duck;
        bit pulse;
    } mdl_t;

    mdl_t m0, m1;

    // Reference: one clock edge of the dino's vertical motion, straight from the rules.
    function automatic mdl_t mstep(mdl_t m, int maxh, bit r, bit t, logic [1:0] g, bit j, bit d);
        mdl_t n;
        int s, dec, term;
        n = m;
        n.pulse = 1'b0;
        if (r) begin
            n.h = 0; n.v = 0; n.air = 0; n.duck = 0;
            return n;
        end
        if (!t || g == 2'b01) return n;
        if (g != 2'b10) begin
            n.h = 0; n.v = 0; n.air = 0; n.duck = 0;
            return n;
        end
        if (!m.air) begin
            if (j && !d) begin
                n.h = JV; n.v = JV - G; n.air = 1; n.pulse = 1; n.duck = 0;
            end else begin
                n.duck = d;
            end
        end else begin
            n.duck = 0;
            dec = G;
            term = -JV;
`ifdef DINO_FAST_DROP_EN
            if (d) begin
                dec = 3 * G;
                term = -2 * JV;
            end
`endif
            s = m.h + m.v;
            if (s <= 0) begin
                n.h = 0; n.v = 0; n.air = 0;
            end else if (s >= maxh) begin
                n.h = maxh; n.v = 0;
            end else begin
                n.h = s;
                n.v = (m.v - dec < term) ? term : m.v - dec;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit t, input logic [1:0] g, input bit j, input bit d);
        rst = r; frameTick = t; gameState = g; jumpBtn = j; duckBtn = d;
        @(posedge clk);
        m0 = mstep(m0, MAXH0, r, t, g, j, d);
        m1 = mstep(m1, MAXH1, r, t, g, j, d);
        #1;
        chk("height",    int'(h0),    m0.h);
        chk("airborne",  int'(air0),  int'(m0.air));
        chk("onground",  int'(gnd0),  int'(!m0.air));
        chk("isduck",    int'(duck0), int'(m0.duck));
        chk("jumppulse", int'(pls0),  int'(m0.pulse));
        chk("c_height",  int'(h1),    m1.h);
        chk("c_airborne",int'(air1),  int'(m1.air));
        chk("c_isduck",  int'(duck1), int'(m1.duck));
        chk("c_pulse",   int'(pls1),  int'(m1.pulse));
        @(negedge clk);
    endtask

    int exp_h1[25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                       78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

    initial begin
        int pulses, airTicks, maxC;
        m0 = '0;
        m1 = '0;

        // Reset state
        step(1, 0, 2'b10, 0, 0);
        step(1, 1, 2'b10, 1, 0);
        chk("rst_height", int'(h0), 0);
        chk("rst_onground", int'(gnd0), 1);

        // Full jump with default physics; clamped instance rides along
        pulses = 0; airTicks = 0; maxC = 0;
        for (int i = 0; i < 25; i++) begin
            step(0, 1, 2'b10, (i == 0), 0);
            chk("jump_profile", int'(h0), exp_h1[i]);
            pulses += int'(pls0) + 0;
            airTicks += int'(air0);
            if (int'(h1) > maxC) maxC = int'(h1);
            if (i < 24) step(0, 0, 2'b10, 0, 0);
        end
        chk("pulse_count", pulses, 1);
        chk("air_ticks", airTicks, 24);
        chk("landed", int'(gnd0), 1);
        chk("clamp_peak", maxC, MAXH1);
        for (int i = 0; i < 12; i++) step(0, 1, 2'b10, 0, 0);

        // Jump and duck together: duck wins
        step(0, 1, 2'b10, 1, 1);
        chk("jd_duck", int'(duck0), 1);
        chk("jd_air", int'(air0), 0);
        step(0, 1, 2'b10, 0, 0);
        chk("jd_release", int'(duck0), 0);

        // Freeze on OVER mid-air, then IDLE grounds
        for (int i = 0; i < 5; i++) step(0, 1, 2'b10, (i == 0), 0);
        chk("over_entry", int'(h0), 50);
        for (int i = 0; i < 10; i++) step(0, 1, 2'b01, 1, 0);
        chk("over_hold", int'(h0), 50);
        chk("over_air", int'(air0), 1);
        step(0, 1, 2'b00, 0, 0);
        chk("idle_ground", int'(h0), 0);
        chk("idle_onground", int'(gnd0), 1);

        // Reset mid-jump without frameTick
        for (int i = 0; i < 7; i++) step(0, 1, 2'b10, (i == 0), 0);
        step(1, 0, 2'b10, 0, 0);
        chk("midrst_height", int'(h0), 0);
        chk("midrst_onground", int'(gnd0), 1);

`ifdef DINO_FAST_DROP_EN
        // Fast drop from the peak
        begin
            int landTick;
            landTick = 0;
            for (int i = 1; i <= 21; i++) begin
                step(0, 1, 2'b10, (i == 1), (i >= 13));
                if (landTick == 0 && i > 1 && !air0) landTick = i;
                if (i == 20) chk("fd_duck_landing", int'(duck0), 0);
            end
            chk("fd_land_tick", landTick, 20);
            chk("fd_duck_after", int'(duck0), 1);
        end
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int gs;
            logic [1:0] g;
            gs = $urandom_range(0, 9);
            g = (gs < 7) ? 2'b10 : (gs == 7) ? 2'b01 : (gs == 8) ? 2'b00 : 2'b11;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), g,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
